pb_port_master: RTL and testbench
=================================

# pb_port_master

PicoBlaze-style port-bus initiator. It accepts single read, write and (optionally) read-modify-write commands on a valid/ready command channel. It drives `port_id`, `out_port`, `read_strobe` and `write_strobe` toward port-mapped peripherals and returns one response per command. It replaces the PicoBlaze core wherever a host (debug bridge, DMA sequencer, test harness) must reach the same peripheral register banks, including peripherals that register their read data.

## Interface
- `READ_LATENCY`, default 1: cycles from first `port_id` cycle to valid `in_port`. Legal range 1..15.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_op`  in  2  00 read, 01 write, 10 read-modify-write, 11 reserved (decoded as read).
- `cmd_addr`  in  8  target port address.
- `cmd_wdata`  in  8  write data.
- `cmd_mask`  in  8  RMW bit mask (1 = take bit from `cmd_wdata`).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`.
- `rsp_rdata`  out  8  read data: old value for RMW, 0x00 for write.
- `port_id`  out  8  peripheral address.
- `out_port`  out  8  peripheral write data.
- `in_port`  in  8  peripheral read data.
- `read_strobe`  out  1  one-cycle read pulse.
- `write_strobe`  out  1  one-cycle write pulse.

## Operation
- States: IDLE, SETUP, RSTB, WAIT, WSTB, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid`: latch op, address, wdata and mask; go to SETUP.
- SETUP:
  - `port_id` = address and `out_port` = wdata, both driven; no strobe.
  - Read/RMW go to RSTB; write goes to WSTB.
- RSTB: `read_strobe` = 1 for exactly this cycle.
  - `READ_LATENCY` = 1: sample `in_port` at the edge ending RSTB.
  - Otherwise: load the latency counter with `READ_LATENCY`−2 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - `in_port` is sampled at the edge where the counter is 0.
  - Then go to RESP (read) or WSTB (RMW).
- RMW write value = (old & ~mask) | (wdata & mask). It is placed on `out_port` in the WSTB cycle.
- WSTB: `write_strobe` = 1 for exactly this cycle; then go to RESP.
- RESP:
  - Hold `rsp_valid` = 1 and stable `rsp_rdata` until `rsp_ready`.
  - Then go to IDLE.
- `port_id` stays constant from SETUP through RESP. It retains its last value in IDLE; it never glitches to an unrelated address mid-command.
- `cmd_valid` outside IDLE is ignored. No command is queued.
- Strobes are mutually exclusive and never asserted outside RSTB/WSTB.

## Timing
- Reset values (all outputs):
  - `cmd_ready` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0x00.
  - `port_id` = 0x00, `out_port` = 0x00.
  - Both strobes = 0.
- State returns to IDLE on reset; `cmd_ready` rises on the first edge after reset deasserts.
- Reset mid-command: strobes drop immediately and asynchronously. The command is discarded with no response.
- Command accepted at edge E0:
  - SETUP is cycle 1 and RSTB/WSTB is cycle 2.
  - Read with `READ_LATENCY` = L: `rsp_valid` first high in cycle 2+L.
  - Write: `rsp_valid` first high in cycle 3.
  - RMW: `rsp_valid` first high in cycle 3+L.
- With `rsp_ready` held high:
  - `rsp_valid` lasts one cycle.
  - `cmd_ready` is high in the following cycle.
  - Minimum write period is 4 cycles.
- `rsp_ready` high before `rsp_valid` is harmless. The handshake completes in the first RESP cycle.

## Configuration
- `PB_PORT_MASTER_RMW_EN` defined: op 10 performs read-modify-write as above.
- Macro absent:
  - op 10 is executed as a plain read.
  - WSTB is reached only from SETUP.
  - `cmd_mask` is unused.
  - Mask logic and RMW path are not synthesized.

## Structure
- Shared package `pb_port_pkg`:
  - op encodings `PB_OP_READ` = 2'b00, `PB_OP_WRITE` = 2'b01, `PB_OP_RMW` = 2'b10.
  - State enum.
  - `PB_MAX_READ_LATENCY` = 15.
- No sub-module: the latency counter and FSM stay in one module.

## Test plan
- Write 0x5A to 0x01 against a register-bank responder:
  - `write_strobe` high exactly cycle 2 with `port_id` = 0x01 and `out_port` = 0x5A.
  - Register reads back 0x5A.
- Read 0x02 with `READ_LATENCY` = 1, responder returning 0x13 registered:
  - `read_strobe` high cycle 2.
  - `rsp_rdata` = 0x13 and `rsp_valid` in cycle 3.
- `READ_LATENCY` = 3, responder delaying data 3 cycles:
  - `rsp_valid` in cycle 5.
  - Value 0xC4 correct; `port_id` stable throughout.
- RMW (macro on) on 0x03 holding 0xF0, wdata 0x0F, mask 0x3C:
  - `rsp_rdata` = 0xF0.
  - Written value = 0xCC.
  - `write_strobe` exactly once.
- `rsp_ready` held low 5 cycles:
  - `rsp_valid` and `rsp_rdata` stable.
  - `cmd_valid` ignored.
  - Completes on release.
- Reset asserted during RSTB:
  - `read_strobe` drops immediately.
  - No `rsp_valid`.
  - `cmd_ready` = 1 one edge after release.

Source files
------------

// File: rtl/pb_port_pkg.sv
// Shared definitions for the PicoBlaze-style port-bus initiator: op encodings,
// FSM states, command kinds and the read-modify-write merge helper.
package pb_port_pkg;

   localparam logic [1:0] PB_OP_READ  = 2'b00;
   localparam logic [1:0] PB_OP_WRITE = 2'b01;
   localparam logic [1:0] PB_OP_RMW   = 2'b10;

   localparam int PB_MAX_READ_LATENCY = 15;

   typedef enum logic [2:0] {
      PB_IDLE,
      PB_SETUP,
      PB_RSTB,
      PB_WAIT,
      PB_WSTB,
      PB_RESP
   } pb_state_t;

   typedef enum logic [1:0] {
      PB_KIND_READ,
      PB_KIND_WRITE,
      PB_KIND_RMW
   } pb_kind_t;

   // Reserved op 11 falls back to a read; RMW collapses to a read when disabled.
   function automatic pb_kind_t pb_decode_op(input logic [1:0] op, input logic rmw_en);
      pb_kind_t kind;
      case (op)
         PB_OP_READ:  kind = PB_KIND_READ;
         PB_OP_WRITE: kind = PB_KIND_WRITE;
         PB_OP_RMW:   kind = rmw_en ? PB_KIND_RMW : PB_KIND_READ;
         default:     kind = PB_KIND_READ;
      endcase
      return kind;
   endfunction

   function automatic logic [7:0] pb_rmw_merge(input logic [7:0] old_val,
                                               input logic [7:0] wdata,
                                               input logic [7:0] mask);
      return (old_val & ~mask) | (wdata & mask);
   endfunction

endpackage

// File: rtl/pb_port_master.sv
// Port-bus initiator: one read/write/RMW command in, one response out.
// Read-modify-write is built only when PB_PORT_MASTER_RMW_EN is defined.
module pb_port_master
   import pb_port_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   input  logic [7:0] cmd_mask,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic [7:0] port_id,
   output logic [7:0] out_port,
   input  logic [7:0] in_port,
   output logic       read_strobe,
   output logic       write_strobe
);

   localparam int              CNT_W       = $clog2(PB_MAX_READ_LATENCY + 1);
   localparam logic            SINGLE_LAT  = (READ_LATENCY == 1);
   localparam logic [CNT_W-1:0] LAT_LOAD   = (READ_LATENCY >= 2) ? CNT_W'(READ_LATENCY - 2)
                                                                 : '0;
`ifdef PB_PORT_MASTER_RMW_EN
   localparam logic RMW_EN = 1'b1;
`else
   localparam logic RMW_EN = 1'b0;
`endif

   pb_state_t        state, state_nxt;
   pb_state_t        after_read;
   pb_kind_t         kind_q;
   logic [CNT_W-1:0] lat_cnt;
   logic             armed;
   logic             accept;
   logic             sample;

`ifdef PB_PORT_MASTER_RMW_EN
   logic [7:0] wdata_q;
   logic [7:0] mask_q;

   assign after_read = (kind_q == PB_KIND_RMW) ? PB_WSTB : PB_RESP;
`else
   logic mask_unused;

   assign mask_unused = ^cmd_mask;
   assign after_read  = PB_RESP;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= PB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Strobes and handshakes decode straight from the state register, so an
   // asynchronous reset removes them without waiting for a clock edge.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // infer a latch.
      state_nxt    = state;
      cmd_ready    = 1'b0;
      rsp_valid    = 1'b0;
      read_strobe  = 1'b0;
      write_strobe = 1'b0;
      accept       = 1'b0;
      sample       = 1'b0;

      case (state)
         PB_IDLE: begin
            cmd_ready = armed;
            if (cmd_valid && armed) begin
               accept    = 1'b1;
               state_nxt = PB_SETUP;
            end
         end
         PB_SETUP: begin
            state_nxt = (kind_q == PB_KIND_WRITE) ? PB_WSTB : PB_RSTB;
         end
         PB_RSTB: begin
            read_strobe = 1'b1;
            if (SINGLE_LAT) begin
               sample    = 1'b1;
               state_nxt = after_read;
            end else begin
               state_nxt = PB_WAIT;
            end
         end
         PB_WAIT: begin
            if (lat_cnt == '0) begin
               sample    = 1'b1;
               state_nxt = after_read;
            end
         end
         PB_WSTB: begin
            write_strobe = 1'b1;
            state_nxt    = PB_RESP;
         end
         PB_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = PB_IDLE;
            end
         end
         default: begin
            state_nxt = PB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed     <= 1'b0;
         kind_q    <= PB_KIND_READ;
         lat_cnt   <= '0;
         port_id   <= 8'h00;
         out_port  <= 8'h00;
         rsp_rdata <= 8'h00;
      end else begin
         // Holds cmd_ready low until the first edge after reset release.
         armed <= 1'b1;

         if (accept) begin
            kind_q    <= pb_decode_op(cmd_op, RMW_EN);
            port_id   <= cmd_addr;
            out_port  <= cmd_wdata;
            rsp_rdata <= 8'h00;
         end

         if (state == PB_RSTB) begin
            lat_cnt <= LAT_LOAD;
         end else if (state == PB_WAIT) begin
            lat_cnt <= lat_cnt - 1'b1;
         end

         if (sample) begin
            rsp_rdata <= in_port;
`ifdef PB_PORT_MASTER_RMW_EN
            if (kind_q == PB_KIND_RMW) begin
               out_port <= pb_rmw_merge(in_port, wdata_q, mask_q);
            end
`endif
         end
      end
   end

`ifdef PB_PORT_MASTER_RMW_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdata_q <= 8'h00;
         mask_q  <= 8'h00;
      end else if (accept) begin
         wdata_q <= cmd_wdata;
         mask_q  <= cmd_mask;
      end
   end
`endif

endmodule

// File: tb/tb_pb_port_master.sv
// Directed bench for pb_port_master: one instance at READ_LATENCY 1 and one at 3,
// each facing a register-bank responder whose read data is pipelined to match.
module tb_pb_port_master;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Instance with READ_LATENCY = 1
   logic       c1_valid, c1_ready;
   logic [1:0] c1_op;
   logic [7:0] c1_addr, c1_wdata, c1_mask;
   logic       r1_valid, r1_ready;
   logic [7:0] r1_rdata;
   logic [7:0] p1_id, p1_out, p1_in;
   logic       p1_rs, p1_ws;

   // Instance with READ_LATENCY = 3
   logic       c3_valid, c3_ready;
   logic [1:0] c3_op;
   logic [7:0] c3_addr, c3_wdata, c3_mask;
   logic       r3_valid, r3_ready;
   logic [7:0] r3_rdata;
   logic [7:0] p3_id, p3_out, p3_in;
   logic       p3_rs, p3_ws;

   pb_port_master #(.READ_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst_n),
      .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op),
      .cmd_addr(c1_addr), .cmd_wdata(c1_wdata), .cmd_mask(c1_mask),
      .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_rdata(r1_rdata),
      .port_id(p1_id), .out_port(p1_out), .in_port(p1_in),
      .read_strobe(p1_rs), .write_strobe(p1_ws)
   );

   pb_port_master #(.READ_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(rst_n),
      .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
      .cmd_addr(c3_addr), .cmd_wdata(c3_wdata), .cmd_mask(c3_mask),
      .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_rdata(r3_rdata),
      .port_id(p3_id), .out_port(p3_out), .in_port(p3_in),
      .read_strobe(p3_rs), .write_strobe(p3_ws)
   );

   // Register-bank responders with registered read data
   logic [7:0] bank1 [0:255];
   logic [7:0] bank3 [0:255];
   logic [7:0] rd1, rd3_a, rd3_b, rd3_c;
   int         ws1_count = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) bank1[i] <= 8'h00;
         bank1[2] <= 8'h13;
         bank1[3] <= 8'hF0;
         rd1      <= 8'h00;
      end else begin
         if (p1_ws) bank1[p1_id] <= p1_out;
         rd1 <= bank1[p1_id];
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) bank3[i] <= 8'h00;
         bank3[4] <= 8'hC4;
         rd3_a    <= 8'h00;
         rd3_b    <= 8'h00;
         rd3_c    <= 8'h00;
      end else begin
         if (p3_ws) bank3[p3_id] <= p3_out;
         rd3_a <= bank3[p3_id];
         rd3_b <= rd3_a;
         rd3_c <= rd3_b;
      end
   end

   always @(posedge clk) begin
      if (p1_ws === 1'b1) ws1_count <= ws1_count + 1;
   end

   assign p1_in = rd1;
   assign p3_in = rd3_c;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue1(input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] mask);
      check_bit("issue1_ready", c1_ready, 1'b1);
      c1_valid = 1'b1;
      c1_op    = op;
      c1_addr  = addr;
      c1_wdata = wdata;
      c1_mask  = mask;
      tick();
      c1_valid = 1'b0;
   endtask

   int ws_before;

   initial begin
      rst_n    = 1'b0;
      c1_valid = 1'b0; c1_op = 2'b00; c1_addr = 8'h00; c1_wdata = 8'h00; c1_mask = 8'h00;
      r1_ready = 1'b1;
      c3_valid = 1'b0; c3_op = 2'b00; c3_addr = 8'h00; c3_wdata = 8'h00; c3_mask = 8'h00;
      r3_ready = 1'b1;

      // Reset values
      #1;
      check_bit("rst_cmd_ready", c1_ready, 1'b0);
      check_bit("rst_rsp_valid", r1_valid, 1'b0);
      check("rst_rsp_rdata", r1_rdata, 8'h00);
      check("rst_port_id", p1_id, 8'h00);
      check("rst_out_port", p1_out, 8'h00);
      check_bit("rst_read_strobe", p1_rs, 1'b0);
      check_bit("rst_write_strobe", p1_ws, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_bit("release_ready_low", c1_ready, 1'b0);
      tick();
      check_bit("ready_after_edge", c1_ready, 1'b1);
      check_bit("ready_after_edge_l3", c3_ready, 1'b1);

      // Write 0x5A to 0x01
      issue1(2'b01, 8'h01, 8'h5A, 8'h00);
      check_bit("wr_c1_wstb", p1_ws, 1'b0);
      check_bit("wr_c1_rstb", p1_rs, 1'b0);
      check("wr_c1_port_id", p1_id, 8'h01);
      check("wr_c1_out_port", p1_out, 8'h5A);
      check_bit("wr_c1_ready", c1_ready, 1'b0);
      tick();
      check_bit("wr_c2_wstb", p1_ws, 1'b1);
      check_bit("wr_c2_rstb", p1_rs, 1'b0);
      check("wr_c2_port_id", p1_id, 8'h01);
      check("wr_c2_out_port", p1_out, 8'h5A);
      check_bit("wr_c2_rsp_valid", r1_valid, 1'b0);
      tick();
      check_bit("wr_c3_wstb", p1_ws, 1'b0);
      check_bit("wr_c3_rsp_valid", r1_valid, 1'b1);
      check("wr_c3_rsp_rdata", r1_rdata, 8'h00);
      check("wr_bank", bank1[1], 8'h5A);
      tick();
      check_bit("wr_c4_rsp_valid", r1_valid, 1'b0);
      check_bit("wr_c4_ready", c1_ready, 1'b1);

      // Read 0x02 with READ_LATENCY = 1
      issue1(2'b00, 8'h02, 8'h00, 8'h00);
      check_bit("rd_c1_rstb", p1_rs, 1'b0);
      check("rd_c1_port_id", p1_id, 8'h02);
      tick();
      check_bit("rd_c2_rstb", p1_rs, 1'b1);
      check_bit("rd_c2_wstb", p1_ws, 1'b0);
      check_bit("rd_c2_rsp_valid", r1_valid, 1'b0);
      tick();
      check_bit("rd_c3_rsp_valid", r1_valid, 1'b1);
      check("rd_c3_rsp_rdata", r1_rdata, 8'h13);
      check_bit("rd_c3_rstb", p1_rs, 1'b0);
      tick();

      // Read back register 0x01; reserved op 11 decodes as read
      issue1(2'b11, 8'h01, 8'h00, 8'h00);
      tick();
      check_bit("rb_c2_rstb", p1_rs, 1'b1);
      tick();
      check_bit("rb_c3_rsp_valid", r1_valid, 1'b1);
      check("rb_c3_rsp_rdata", r1_rdata, 8'h5A);
      tick();

      // Response back-pressure: rsp_ready low, a competing command offered
      ws_before = ws1_count;
      r1_ready  = 1'b0;
      issue1(2'b00, 8'h02, 8'h00, 8'h00);
      c1_valid = 1'b1; c1_op = 2'b01; c1_addr = 8'h07; c1_wdata = 8'h77;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check_bit("bp_rsp_valid", r1_valid, 1'b1);
         check("bp_rsp_rdata", r1_rdata, 8'h13);
         check_bit("bp_cmd_ready", c1_ready, 1'b0);
         check("bp_port_id", p1_id, 8'h02);
         tick();
      end
      c1_valid = 1'b0;
      r1_ready = 1'b1;
      check_bit("bp_still_valid", r1_valid, 1'b1);
      tick();
      check_bit("bp_done_valid", r1_valid, 1'b0);
      check_bit("bp_done_ready", c1_ready, 1'b1);
      check("bp_no_write_bank", bank1[7], 8'h00);
      check("bp_no_write_strobe", 8'(ws1_count - ws_before), 8'h00);

      // READ_LATENCY = 3 read of 0x04
      check_bit("l3_ready", c3_ready, 1'b1);
      c3_valid = 1'b1; c3_op = 2'b00; c3_addr = 8'h04;
      tick();
      c3_valid = 1'b0;
      check("l3_c1_port_id", p3_id, 8'h04);
      check_bit("l3_c1_rstb", p3_rs, 1'b0);
      tick();
      check_bit("l3_c2_rstb", p3_rs, 1'b1);
      check("l3_c2_port_id", p3_id, 8'h04);
      tick();
      check_bit("l3_c3_rsp_valid", r3_valid, 1'b0);
      check_bit("l3_c3_rstb", p3_rs, 1'b0);
      check("l3_c3_port_id", p3_id, 8'h04);
      tick();
      check_bit("l3_c4_rsp_valid", r3_valid, 1'b0);
      check("l3_c4_port_id", p3_id, 8'h04);
      tick();
      check_bit("l3_c5_rsp_valid", r3_valid, 1'b1);
      check("l3_c5_rsp_rdata", r3_rdata, 8'hC4);
      check("l3_c5_port_id", p3_id, 8'h04);
      tick();
      check_bit("l3_c6_rsp_valid", r3_valid, 1'b0);

      // Op 10 on 0x03 holding 0xF0, wdata 0x0F, mask 0x3C
      ws_before = ws1_count;
      issue1(2'b10, 8'h03, 8'h0F, 8'h3C);
      tick();
      check_bit("rmw_c2_rstb", p1_rs, 1'b1);
      tick();
`ifdef PB_PORT_MASTER_RMW_EN
      check_bit("rmw_c3_wstb", p1_ws, 1'b1);
      check_bit("rmw_c3_rstb", p1_rs, 1'b0);
      check("rmw_c3_out_port", p1_out, 8'hCC);
      check("rmw_c3_port_id", p1_id, 8'h03);
      check_bit("rmw_c3_rsp_valid", r1_valid, 1'b0);
      tick();
      check_bit("rmw_c4_rsp_valid", r1_valid, 1'b1);
      check("rmw_c4_rsp_rdata", r1_rdata, 8'hF0);
      check("rmw_bank", bank1[3], 8'hCC);
      check("rmw_wstb_count", 8'(ws1_count - ws_before), 8'h01);
`else
      check_bit("rmw_off_c3_wstb", p1_ws, 1'b0);
      check_bit("rmw_off_c3_rsp_valid", r1_valid, 1'b1);
      check("rmw_off_c3_rsp_rdata", r1_rdata, 8'hF0);
      check("rmw_off_bank", bank1[3], 8'hF0);
      check("rmw_off_wstb_count", 8'(ws1_count - ws_before), 8'h00);
`endif
      tick();

      // Reset asserted during RSTB
      issue1(2'b00, 8'h02, 8'h00, 8'h00);
      tick();
      check_bit("rr_c2_rstb", p1_rs, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("rr_rstb_drop", p1_rs, 1'b0);
      check_bit("rr_rsp_valid", r1_valid, 1'b0);
      check_bit("rr_cmd_ready", c1_ready, 1'b0);
      tick();
      #2;
      rst_n = 1'b1;
      #1;
      check_bit("rr_release_ready", c1_ready, 1'b0);
      tick();
      check_bit("rr_ready_after_edge", c1_ready, 1'b1);
      check_bit("rr_no_rsp_a", r1_valid, 1'b0);
      tick();
      check_bit("rr_no_rsp_b", r1_valid, 1'b0);
      check_bit("rr_no_rstb", p1_rs, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
